// File: rtl/wb_buffer.sv
// -----------------------------------------------------------------------------
// wb_buffer -- write-back buffer for evicted dirty cache lines.
//
// Evicted lines are queued in a small circular FIFO and drained to memory one
// at a time.  While a line sits in the buffer, the main cache FSM can look it
// up combinationally, so a miss that lands on a line still waiting to be
// written back is served from here instead of from stale memory.
//
// Ports
//   aclk_i          : single clock, all state updates on the rising edge
//   arstn_i         : asynchronous active-low reset
//   push_valid_i    : evicted dirty line offered by the main FSM
//   push_ready_o    : buffer accepts a push this cycle (not full)
//   push_addr_i     : line address of the evicted line
//   push_data_i     : evicted line data
//   lkp_addr_i      : lookup address from the main FSM
//   wb_hit_o        : lookup address present in a valid entry
//   wb_r_data_o     : data of the youngest matching entry, zero on miss
//   mem_wr_valid_o  : head entry offered to memory (not empty)
//   mem_wr_addr_o   : head entry address
//   mem_wr_data_o   : head entry data
//   mem_wr_ready_i  : memory accepts the head entry
//   count_o         : number of valid entries
//   full_o, empty_o : count_o == DEPTH / count_o == 0
// -----------------------------------------------------------------------------
module wb_buffer #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4    // power of two, >= 2
) (
  input  logic                         aclk_i,
  input  logic                         arstn_i,

  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [ADDR_W-1:0]            push_addr_i,
  input  logic [LINE_W-1:0]            push_data_i,

  input  logic [ADDR_W-1:0]            lkp_addr_i,
  output logic                         wb_hit_o,
  output logic [LINE_W-1:0]            wb_r_data_o,

  output logic                         mem_wr_valid_o,
  output logic [ADDR_W-1:0]            mem_wr_addr_o,
  output logic [LINE_W-1:0]            mem_wr_data_o,
  input  logic                         mem_wr_ready_i,

  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];

  logic              push_fire;
  logic              pop_fire;

  // ---------------------------------------------------------------------------
  // Status and handshakes
  // ---------------------------------------------------------------------------
  // Full/empty come from the registered count only, so push_ready_o never
  // depends on mem_wr_ready_i: a push into a full buffer waits one cycle even
  // when a pop is happening in the same cycle.
  assign full_o       = (cnt_q == CNT_FULL);
  assign empty_o      = (cnt_q == '0);
  assign count_o      = cnt_q;
  assign push_ready_o = !full_o;

  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_fire     = mem_wr_valid_o && mem_wr_ready_i;

  // The head is only replaced by a pop, so address/data stay stable while the
  // memory side stalls.
  assign mem_wr_valid_o = !empty_o;
  assign mem_wr_addr_o  = addr_q[rp_q];
  assign mem_wr_data_o  = data_q[rp_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    // Push and pop never target the same slot: a push needs a non-full buffer
    // and a pop a non-empty one, so wp == rp cannot hold with both firing.
    if (push_fire) begin
      valid_d[wp_q] = 1'b1;
      wp_d          = wp_q + PTR_W'(1);
    end

    if (pop_fire) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PTR_W'(1);
    end

    unique case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line storage
  // ---------------------------------------------------------------------------
  // NOTE: the address/data arrays have no reset; an entry is only ever read
  // through its valid bit or through the head when count is non-zero, so
  // power-up contents are never observed and the arrays map onto plain flops
  // or RAM without a reset tree.
  always_ff @(posedge aclk_i) begin
    if (push_fire) begin
      addr_q[wp_q] <= push_addr_i;
      data_q[wp_q] <= push_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  // Walk the entries in age order, oldest (rp) to youngest (wp-1); a later
  // match overrides an earlier one, so the youngest copy of a line wins.
  // Only registered valid bits are consulted: a line pushed this cycle shows
  // up next cycle, a line popped this cycle still hits this cycle.
  logic [PTR_W-1:0]  lkp_idx;
  logic              lkp_hit;
  logic [LINE_W-1:0] lkp_data;

  always_comb begin
    lkp_idx  = rp_q;
    lkp_hit  = 1'b0;
    lkp_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lkp_idx = rp_q + PTR_W'(k);
      if (valid_q[lkp_idx] && (addr_q[lkp_idx] == lkp_addr_i)) begin
        lkp_hit  = 1'b1;
        lkp_data = data_q[lkp_idx];
      end
    end
  end

  assign wb_hit_o    = lkp_hit;
  assign wb_r_data_o = lkp_data;

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter ADDR_W, default 32, line address width.
REQ-002 Parameter LINE_W, default 128, cache line data width.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 aclk_i  in  1  single clock; all state on rising edge.
REQ-005 arstn_i  in  1  asynchronous, active-low reset.
REQ-006 push_valid_i  in  1  evicted dirty line offered by main FSM.
REQ-007 push_ready_o  out  1  buffer accepts push this cycle.
REQ-008 push_addr_i  in  ADDR_W  line address of evicted line.
REQ-009 push_data_i  in  LINE_W  evicted line data.
REQ-010 lkp_addr_i  in  ADDR_W  lookup address from main FSM.
REQ-011 wb_hit_o  out  1  lookup address present in buffer (drives main FSM wb_hit_i).
REQ-012 wb_r_data_o  out  LINE_W  data of hitting entry (drives main FSM wb_r_data_i).
REQ-013 mem_wr_valid_o  out  1  head entry offered to memory.
REQ-014 mem_wr_addr_o  out  ADDR_W  head entry address.
REQ-015 mem_wr_data_o  out  LINE_W  head entry data.
REQ-016 mem_wr_ready_i  in  1  memory accepts head entry.
REQ-017 count_o  out  $clog2(DEPTH+1)  valid entry count.
REQ-018 full_o / empty_o  out  1 each  count_o==DEPTH / count_o==0.

Function
REQ-019 Storage: circular FIFO, DEPTH entries of {addr, data, valid}; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-020 push_ready_o = !full_o, registered-state only; never depends combinationally on mem_wr_ready_i.
REQ-021 Push fires when push_valid_i && push_ready_o: entry[wp] written, valid set, wp increments next edge.
REQ-022 mem_wr_valid_o = !empty_o; mem_wr_addr_o/mem_wr_data_o = entry[rp].
REQ-023 Pop fires when mem_wr_valid_o && mem_wr_ready_i: entry[rp].valid cleared, rp increments next edge.
REQ-024 Once mem_wr_valid_o rises, it and address/data stay stable until pop fires.
REQ-025 Push and pop same cycle: count unchanged; both pointers advance.
REQ-026 Full with pop pending: push refused that cycle (push_ready_o low); push accepted next cycle.
REQ-027 count_o: +1 on push only, -1 on pop only, unchanged otherwise; never exceeds DEPTH nor wraps below 0.
REQ-028 Lookup combinational: wb_hit_o=1 if any valid entry addr == lkp_addr_i; zero-latency, same cycle.
REQ-029 Multiple matching entries: wb_r_data_o from youngest (closest behind wp).
REQ-030 wb_hit_o=0 -> wb_r_data_o all zeros.
REQ-031 Entry being pushed this cycle not visible to lookup until next cycle.
REQ-032 Entry being popped this cycle still hits this cycle; gone next cycle.
REQ-033 push_valid_i with push_ready_o low: no state change; upstream holds request.

Reset
REQ-034 arstn_i low: wp=0, rp=0, count_o=0, all valid bits 0, immediately, independent of clock.
REQ-035 Reset outputs: push_ready_o=1, mem_wr_valid_o=0, wb_hit_o=0, wb_r_data_o=0, empty_o=1, full_o=0, count_o=0; data storage need not be cleared.
REQ-036 Reset mid-transfer discards all entries; mem_wr_valid_o drops asynchronously.
REQ-037 First push accepted on first rising edge after arstn_i deasserts.

Verification
REQ-038 Push addr 0x100 data A, mem_wr_ready_i=0 -> next cycle mem_wr_valid_o=1, addr 0x100, count_o=1; lkp 0x100 -> wb_hit_o=1, wb_r_data_o=A.
REQ-039 Push 4 lines, ready=0 -> full_o=1, push_ready_o=0; 5th push held; ready=1 one cycle -> next cycle 5th push accepted, count_o=4.
REQ-040 Push 0x200 data A then 0x200 data B -> lookup 0x200 returns B; after first pop still B; after second pop wb_hit_o=0, data 0.
REQ-041 count_o=2, push and pop same cycle -> count_o stays 2, FIFO order preserved through pointer wrap over 12 lines.
REQ-042 mem_wr_ready_i held 0 for 10 cycles -> mem_wr_addr_o/data constant, valid held high.
REQ-043 arstn_i low mid-stream with count_o=3 -> same cycle mem_wr_valid_o=0, wb_hit_o=0, count_o=0; post-reset pushes start at entry 0.
